// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: merges ALU and load writebacks into the single register-file
// write port. Each requester has a 2-entry FIFO. Round-robin arbitration picks
// one head per cycle, and a per-register busy mask is exported for hazard checks.
module rf_write_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DEPTH  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  input  logic [ADDR_W-1:0]    req0_addr,
  input  logic [DATA_W-1:0]    req0_data,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [ADDR_W-1:0]    req1_addr,
  input  logic [DATA_W-1:0]    req1_data,
  output logic                 req1_ready,
  output logic                 rf_we,
  output logic [ADDR_W-1:0]    rf_addr,
  output logic [DATA_W-1:0]    rf_data,
  output logic [2**ADDR_W-1:0] busy_mask
);

  localparam int unsigned NREG  = 2 ** ADDR_W;
  localparam int unsigned CNT_W = 2;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  // Queue storage and bookkeeping, indexed by requester
  wr_t              mem  [2][DEPTH];
  logic [CNT_W-1:0] cnt  [2];
  logic             wptr [2];
  logic             rptr [2];
  logic             prio;

  logic             in_valid [2];
  wr_t              in_wr    [2];
  logic             ready    [2];
  logic             push     [2];
  logic             pop      [2];
  logic             gnt_any;
  logic             gnt_sel;
  wr_t              gnt_wr;
  logic [NREG-1:0]  busy_c;

  // Gather the two requester ports into indexable form
  always_comb begin
    in_valid[0]   = req0_valid;
    in_valid[1]   = req1_valid;
    in_wr[0].addr = req0_addr;
    in_wr[0].data = req0_data;
    in_wr[1].addr = req1_addr;
    in_wr[1].data = req1_data;
  end

  // Ready depends only on occupancy and reset; writes to r0 are dropped here
  always_comb begin
    for (int n = 0; n < 2; n++) begin
      ready[n] = rst & (cnt[n] != CNT_W'(DEPTH));
      push[n]  = in_valid[n] & ready[n] & (in_wr[n].addr != '0);
    end
  end

  assign req0_ready = ready[0];
  assign req1_ready = ready[1];

  // Arbitration: a lone non-empty queue wins, otherwise the priority pointer decides
  always_comb begin
    gnt_any = (cnt[0] != '0) | (cnt[1] != '0);
    gnt_sel = 1'b0;
    if ((cnt[0] != '0) && (cnt[1] != '0)) begin
      gnt_sel = prio;
    end else if (cnt[1] != '0) begin
      gnt_sel = 1'b1;
    end
    pop[0] = gnt_any & ~gnt_sel;
    pop[1] = gnt_any & gnt_sel;
    gnt_wr = gnt_sel ? mem[1][rptr[1]] : mem[0][rptr[0]];
  end

  // Queue payload storage; contents are qualified by cnt, so no reset is needed
  always_ff @(posedge clk) begin
    for (int n = 0; n < 2; n++) begin
      if (push[n]) begin
        mem[n][wptr[n]] <= in_wr[n];
      end
    end
  end

  // Queue pointers/counts, priority pointer and the registered write port
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int n = 0; n < 2; n++) begin
        cnt[n]  <= '0;
        wptr[n] <= 1'b0;
        rptr[n] <= 1'b0;
      end
      prio    <= 1'b0;
      rf_we   <= 1'b0;
      rf_addr <= '0;
      rf_data <= '0;
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (push[n]) begin
          wptr[n] <= ~wptr[n];
        end
        if (pop[n]) begin
          rptr[n] <= ~rptr[n];
        end
        if (push[n] && !pop[n]) begin
          cnt[n] <= cnt[n] + CNT_W'(1);
        end else if (!push[n] && pop[n]) begin
          cnt[n] <= cnt[n] - CNT_W'(1);
        end
      end
      if (gnt_any) begin
        prio    <= ~gnt_sel;
        rf_we   <= 1'b1;
        rf_addr <= gnt_wr.addr;
        rf_data <= gnt_wr.data;
      end else begin
        rf_we   <= 1'b0;
      end
    end
  end

  // Pending-write flags: every live queue entry plus the write now on the port
  always_comb begin
    busy_c = '0;
    for (int n = 0; n < 2; n++) begin
      if (cnt[n] != '0) begin
        busy_c[mem[n][rptr[n]].addr] = 1'b1;
      end
      if (cnt[n] == CNT_W'(DEPTH)) begin
        busy_c[mem[n][~rptr[n]].addr] = 1'b1;
      end
    end
    if (rf_we) begin
      busy_c[rf_addr] = 1'b1;
    end
    busy_c[0] = 1'b0;
    if (!rst) begin
      busy_c = '0;
    end
  end

  assign busy_mask = busy_c;

endmodule
